// File: rtl/mips_pkg.sv
// mips_pkg
// Shared types and widths for the MIPS register-file writeback path.
//   REG_ADDR_W : register address width (32 registers)
//   DATA_W     : register data width
//   wb_entry_t : one pending register write {wr_reg, data}
//   entry_hits : true when a valid entry targets the probed register
package mips_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] wr_reg;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  function automatic logic entry_hits(wb_entry_t e, logic v, logic [REG_ADDR_W-1:0] q);
    return v && (e.wr_reg == q);
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// regfile_write_arbiter_if
// Bundles every non-clock signal of the register-file write arbiter.
//   pipeline side   : pipe_wr_en/pipe_wr_reg/pipe_wr_data in, pipe_stall out
//   multi-cycle side: mc_valid/mc_wr_reg/mc_wr_data in, mc_ready out
//   hazard side     : query_reg_1/query_reg_2 in, pending_1/pending_2 out
//   register file   : regWrite/write_reg/write_data out, fifo_count out
// The slave modport is the arbiter's view, the master modport is the
// view of whatever drives requests and consumes the results.
interface regfile_write_arbiter_if #(
  parameter int DEPTH = 4
);
  import mips_pkg::*;

  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                  pipe_wr_en;
  logic [REG_ADDR_W-1:0] pipe_wr_reg;
  logic [DATA_W-1:0]     pipe_wr_data;
  logic                  pipe_stall;

  logic                  mc_valid;
  logic                  mc_ready;
  logic [REG_ADDR_W-1:0] mc_wr_reg;
  logic [DATA_W-1:0]     mc_wr_data;

  logic [REG_ADDR_W-1:0] query_reg_1;
  logic [REG_ADDR_W-1:0] query_reg_2;
  logic                  pending_1;
  logic                  pending_2;

  logic                  regWrite;
  logic [REG_ADDR_W-1:0] write_reg;
  logic [DATA_W-1:0]     write_data;
  logic [CNT_W-1:0]      fifo_count;

  modport slave (
    input  pipe_wr_en, pipe_wr_reg, pipe_wr_data,
    input  mc_valid, mc_wr_reg, mc_wr_data,
    input  query_reg_1, query_reg_2,
    output pipe_stall, mc_ready, pending_1, pending_2,
    output regWrite, write_reg, write_data, fifo_count
  );

  modport master (
    output pipe_wr_en, pipe_wr_reg, pipe_wr_data,
    output mc_valid, mc_wr_reg, mc_wr_data,
    output query_reg_1, query_reg_2,
    input  pipe_stall, mc_ready, pending_1, pending_2,
    input  regWrite, write_reg, write_data, fifo_count
  );

endinterface

// File: rtl/wb_fifo.sv
// wb_fifo
// Synchronous FIFO of pending register writes.
//   clk, rst   : clock, synchronous active-high reset
//   push       : store push_entry at the tail (caller never pushes when full)
//   pop        : drop the head (caller never pops when empty)
//   head       : entry at the read pointer
//   count      : number of queued entries
//   empty      : count == 0
//   entries    : raw storage, indexed by slot
//   valid      : per-slot flag, set when the slot currently holds a queued entry
module wb_fifo
  import mips_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wb_entry_t              push_entry,
  input  logic                   pop,
  output wb_entry_t              head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output wb_entry_t              entries [DEPTH],
  output logic [DEPTH-1:0]       valid
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem_q [DEPTH];
  wb_entry_t        mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_entry;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is not reset; only the valid window defined by the pointers matters.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
    mem_q <= mem_d;
  end

  // A slot is live when its distance from the read pointer is below the count.
  always_comb begin
    valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid[i] = ({1'b0, PTR_W'(i) - rd_ptr_q} < count_q);
    end
  end

  assign entries = mem_q;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;
  assign empty   = (count_q == '0);

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter
// Single write port of the register file, shared by the pipeline writeback
// (priority, no backpressure) and a multi-cycle unit whose results wait in
// a small FIFO. A starvation counter eventually stalls the pipeline so the
// FIFO head gets through.
//   clk, rst : clock, synchronous active-high reset
//   bus      : slave modport of regfile_write_arbiter_if (requests in,
//              registered register-file write port and status out)
module regfile_write_arbiter
  import mips_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8
) (
  input logic                    clk,
  input logic                    rst,
  regfile_write_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int SC_W  = $clog2(STARVE_LIMIT + 1);

  logic                  reg_write_q, reg_write_d;
  logic [REG_ADDR_W-1:0] write_reg_q, write_reg_d;
  logic [DATA_W-1:0]     write_data_q, write_data_d;
  logic [SC_W-1:0]       starve_cnt_q, starve_cnt_d;

  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  wb_entry_t             push_entry;
  wb_entry_t             head_entry;
  wb_entry_t             entries [DEPTH];
  logic [DEPTH-1:0]      entry_valid;

  logic                  pipe_stall;
  logic                  mc_ready;
  logic                  pipe_eff;
  logic                  pend_1;
  logic                  pend_2;

  wb_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_entry(push_entry),
    .pop       (fifo_pop),
    .head      (head_entry),
    .count     (fifo_count),
    .empty     (fifo_empty),
    .entries   (entries),
    .valid     (entry_valid)
  );

  // Both handshake outputs come from registered state only, so neither
  // creates a combinational path back into the requesters.
  assign pipe_stall = (starve_cnt_q == SC_W'(STARVE_LIMIT));
  assign mc_ready   = !rst && (fifo_count < CNT_W'(DEPTH));

  // Register 0 is hardwired, so writes to it are accepted and dropped.
  always_comb begin
    pipe_eff   = bus.pipe_wr_en && (bus.pipe_wr_reg != '0) && !pipe_stall;
    fifo_push  = bus.mc_valid && mc_ready && (bus.mc_wr_reg != '0);
    fifo_pop   = !pipe_eff && !fifo_empty;
    push_entry = '{wr_reg: bus.mc_wr_reg, data: bus.mc_wr_data};
  end

  // Output register: pipeline first, then FIFO head; address/data hold when idle.
  always_comb begin
    reg_write_d  = 1'b0;
    write_reg_d  = write_reg_q;
    write_data_d = write_data_q;
    if (pipe_eff) begin
      reg_write_d  = 1'b1;
      write_reg_d  = bus.pipe_wr_reg;
      write_data_d = bus.pipe_wr_data;
    end else if (fifo_pop) begin
      reg_write_d  = 1'b1;
      write_reg_d  = head_entry.wr_reg;
      write_data_d = head_entry.data;
    end
  end

  // Counts cycles the head sat waiting; saturates at the limit, which raises the stall.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (fifo_empty || fifo_pop) begin
      starve_cnt_d = '0;
    end else if (starve_cnt_q != SC_W'(STARVE_LIMIT)) begin
      starve_cnt_d = starve_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      reg_write_q  <= 1'b0;
      write_reg_q  <= '0;
      write_data_q <= '0;
      starve_cnt_q <= '0;
    end else begin
      reg_write_q  <= reg_write_d;
      write_reg_q  <= write_reg_d;
      write_data_q <= write_data_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // A register is pending while queued or while its write is on the port.
  always_comb begin
    pend_1 = 1'b0;
    pend_2 = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (entry_hits(entries[i], entry_valid[i], bus.query_reg_1)) pend_1 = 1'b1;
      if (entry_hits(entries[i], entry_valid[i], bus.query_reg_2)) pend_2 = 1'b1;
    end
    if (reg_write_q && (write_reg_q == bus.query_reg_1)) pend_1 = 1'b1;
    if (reg_write_q && (write_reg_q == bus.query_reg_2)) pend_2 = 1'b1;
    if (bus.query_reg_1 == '0) pend_1 = 1'b0;
    if (bus.query_reg_2 == '0) pend_2 = 1'b0;
  end

  assign bus.pipe_stall = pipe_stall;
  assign bus.mc_ready   = mc_ready;
  assign bus.pending_1  = pend_1;
  assign bus.pending_2  = pend_2;
  assign bus.regWrite   = reg_write_q;
  assign bus.write_reg  = write_reg_q;
  assign bus.write_data = write_data_q;
  assign bus.fifo_count = fifo_count;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb_regfile_write_arbiter
// Directed stimulus for regfile_write_arbiter. A queue-based model of the
// arbiter is checked against every output on every falling edge, and the
// directed sequences add hand-computed expectations at key cycles.
module tb_regfile_write_arbiter;

  localparam int DEPTH = 4;
  localparam int LIMIT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  bit   check_en = 1'b0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  regfile_write_arbiter_if #(.DEPTH(DEPTH)) bus ();

  regfile_write_arbiter #(
    .DEPTH       (DEPTH),
    .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );

  // Model: a plain queue of waiting writes, the write-port contents, and a
  // count of cycles the oldest queued write has been kept waiting.
  typedef struct {
    logic [4:0]  r;
    logic [31:0] d;
  } m_ent_t;

  m_ent_t      mq[$];
  logic        m_rw = 1'b0;
  logic [4:0]  m_wreg = '0;
  logic [31:0] m_wdata = '0;
  int          m_starve = 0;

  always @(posedge clk) begin : model
    bit     stall_now, ready_now, had_work, pipe_go, popped;
    m_ent_t e;
    if (rst) begin
      mq.delete();
      m_rw     = 1'b0;
      m_wreg   = '0;
      m_wdata  = '0;
      m_starve = 0;
    end else begin
      stall_now = (m_starve == LIMIT);
      ready_now = (mq.size() < DEPTH);
      had_work  = (mq.size() != 0);
      pipe_go   = bus.pipe_wr_en && (bus.pipe_wr_reg != 0) && !stall_now;
      popped    = 1'b0;
      if (pipe_go) begin
        m_rw    = 1'b1;
        m_wreg  = bus.pipe_wr_reg;
        m_wdata = bus.pipe_wr_data;
      end else if (had_work) begin
        e       = mq.pop_front();
        m_rw    = 1'b1;
        m_wreg  = e.r;
        m_wdata = e.d;
        popped  = 1'b1;
      end else begin
        m_rw = 1'b0;
      end
      if (had_work && !popped) m_starve = (m_starve < LIMIT) ? m_starve + 1 : LIMIT;
      else m_starve = 0;
      if (bus.mc_valid && ready_now && (bus.mc_wr_reg != 0)) begin
        e.r = bus.mc_wr_reg;
        e.d = bus.mc_wr_data;
        mq.push_back(e);
      end
    end
  end

  function automatic bit model_pending(logic [4:0] q);
    if (q == 0) return 1'b0;
    if (m_rw && (m_wreg == q)) return 1'b1;
    foreach (mq[i]) if (mq[i].r == q) return 1'b1;
    return 1'b0;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("regWrite",   32'(bus.regWrite),   32'(m_rw));
      checkOutput("write_reg",  32'(bus.write_reg),  32'(m_wreg));
      checkOutput("write_data", bus.write_data,      m_wdata);
      checkOutput("fifo_count", 32'(bus.fifo_count), 32'(mq.size()));
      checkOutput("mc_ready",   32'(bus.mc_ready),   32'(!rst && (mq.size() < DEPTH)));
      checkOutput("pipe_stall", 32'(bus.pipe_stall), 32'(m_starve == LIMIT));
      checkOutput("pending_1",  32'(bus.pending_1),  32'(model_pending(bus.query_reg_1)));
      checkOutput("pending_2",  32'(bus.pending_2),  32'(model_pending(bus.query_reg_2)));
    end
  end

  task automatic applyStimulus(input logic pwe, input logic [4:0] preg, input logic [31:0] pdata,
                               input logic mv, input logic [4:0] mreg, input logic [31:0] mdata,
                               input logic [4:0] q1, input logic [4:0] q2);
    @(posedge clk);
    #1;
    bus.pipe_wr_en   = pwe;
    bus.pipe_wr_reg  = preg;
    bus.pipe_wr_data = pdata;
    bus.mc_valid     = mv;
    bus.mc_wr_reg    = mreg;
    bus.mc_wr_data   = mdata;
    bus.query_reg_1  = q1;
    bus.query_reg_2  = q2;
  endtask

  task automatic peek();
    @(negedge clk);
    #2;
  endtask

  task automatic drainFifo();
    int guard;
    guard = 0;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    peek();
    while ((bus.fifo_count != 0) && (guard < 20)) begin
      guard++;
      applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      peek();
    end
    checkOutput("drain_empty", 32'(bus.fifo_count), 32'd0);
  endtask

  typedef struct {
    logic        pwe;
    logic [4:0]  preg;
    logic [31:0] pdata;
    logic        mv;
    logic [4:0]  mreg;
    logic [31:0] mdata;
    logic [4:0]  q1;
    logic [4:0]  q2;
  } vec_t;

  vec_t vecs [8] = '{
    '{1'b1, 5'd4,  32'h40,       1'b1, 5'd4,  32'h44, 5'd4,  5'd0},
    '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  32'h66, 5'd4,  5'd6},
    '{1'b1, 5'd0,  32'h99,       1'b1, 5'd0,  32'h00, 5'd6,  5'd0},
    '{1'b1, 5'd31, 32'hFFFFFFFF, 1'b1, 5'd31, 32'h31, 5'd31, 5'd4},
    '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  5'd31, 5'd6},
    '{1'b1, 5'd2,  32'h22,       1'b1, 5'd2,  32'h02, 5'd2,  5'd31},
    '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  5'd2,  5'd0},
    '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,  5'd0,  5'd0}
  };

  initial begin
    #100000;
    n_fail++;
    $display("[TB] FAIL watchdog: still running at %0t, required finish", $time);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    int waits;
    bus.pipe_wr_en   = 1'b0;
    bus.pipe_wr_reg  = '0;
    bus.pipe_wr_data = '0;
    bus.mc_valid     = 1'b0;
    bus.mc_wr_reg    = '0;
    bus.mc_wr_data   = '0;
    bus.query_reg_1  = '0;
    bus.query_reg_2  = '0;

    // Reset state
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    check_en = 1'b1;
    peek();
    checkOutput("rst_regWrite",   32'(bus.regWrite),   32'd0);
    checkOutput("rst_write_data", bus.write_data,      32'd0);
    checkOutput("rst_fifo_count", 32'(bus.fifo_count), 32'd0);
    checkOutput("rst_mc_ready",   32'(bus.mc_ready),   32'd0);
    checkOutput("rst_pipe_stall", 32'(bus.pipe_stall), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    rst = 1'b0;

    // Pipeline only, then a write to register 0
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    applyStimulus(1'b1, 5'd0, 32'h11111111, 1'b0, 5'd0, 32'h0, 5'd5, 5'd0);
    peek();
    checkOutput("pipe_regWrite",   32'(bus.regWrite),  32'd1);
    checkOutput("pipe_write_reg",  32'(bus.write_reg), 32'd5);
    checkOutput("pipe_write_data", bus.write_data,     32'hDEADBEEF);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    peek();
    checkOutput("reg0_regWrite",   32'(bus.regWrite),  32'd0);
    checkOutput("reg0_write_reg",  32'(bus.write_reg), 32'd5);

    // Multi-cycle result with idle pipeline
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd9, 32'h1234, 5'd9, 5'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    peek();
    checkOutput("mc_count_1",    32'(bus.fifo_count), 32'd1);
    checkOutput("mc_pending_q",  32'(bus.pending_1),  32'd1);
    checkOutput("mc_no_bypass",  32'(bus.regWrite),   32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    peek();
    checkOutput("mc_regWrite",   32'(bus.regWrite),  32'd1);
    checkOutput("mc_write_reg",  32'(bus.write_reg), 32'd9);
    checkOutput("mc_write_data", bus.write_data,     32'h1234);
    checkOutput("mc_pending_w",  32'(bus.pending_1), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd0);
    peek();
    checkOutput("mc_pending_off", 32'(bus.pending_1), 32'd0);

    // Fill the FIFO while the pipeline writes every cycle
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1'b1, 5'd3, 32'h300 + k, 1'b1, 5'(10 + k), 32'hA0 + k, 5'd10, 5'd13);
      peek();
      checkOutput("fill_ready", 32'(bus.mc_ready), 32'd1);
    end
    waits = 0;
    applyStimulus(1'b1, 5'd3, 32'h304, 1'b1, 5'd14, 32'hA4, 5'd10, 5'd13);
    peek();
    while (!bus.mc_ready && (waits < 40)) begin
      checkOutput("fill_count_held", 32'(bus.fifo_count), 32'd4);
      waits++;
      applyStimulus(1'b1, 5'd3, 32'h304, 1'b1, 5'd14, 32'hA4, 5'd10, 5'd13);
      peek();
    end
    checkOutput("fill_wait_cycles", 32'(waits), 32'd6);
    drainFifo();

    // Starvation: one queued entry against a pipeline writing every cycle
    applyStimulus(1'b1, 5'd7, 32'h77, 1'b1, 5'd12, 32'h55, 5'd12, 5'd7);
    for (int k = 1; k <= 11; k++) begin
      applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, 5'd0, 32'h0, 5'd12, 5'd7);
      peek();
      checkOutput("starve_stall", 32'(bus.pipe_stall), 32'(k == 9));
      if (k == 10) begin
        checkOutput("starve_head_reg",  32'(bus.write_reg), 32'd12);
        checkOutput("starve_head_data", bus.write_data,     32'h55);
      end
      if (k == 11) begin
        checkOutput("starve_pipe_reg",  32'(bus.write_reg), 32'd7);
        checkOutput("starve_pipe_rw",   32'(bus.regWrite),  32'd1);
      end
    end

    // Multi-cycle write to register 0 completes without queuing
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'hFF, 5'd0, 5'd0);
    peek();
    checkOutput("zero_mc_ready", 32'(bus.mc_ready), 32'd1);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    peek();
    checkOutput("zero_mc_count", 32'(bus.fifo_count), 32'd0);

    // Reset with three entries queued
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 5'd1, 32'h11, 1'b1, 5'(20 + k), 32'h200 + k, 5'd20, 5'd21);
    end
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd20, 5'd21);
    rst = 1'b1;
    peek();
    checkOutput("rstmid_count_before", 32'(bus.fifo_count), 32'd3);
    checkOutput("rstmid_ready_low",    32'(bus.mc_ready),   32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd20, 5'd21);
    rst = 1'b0;
    peek();
    checkOutput("rstmid_count",    32'(bus.fifo_count), 32'd0);
    checkOutput("rstmid_regWrite", 32'(bus.regWrite),   32'd0);
    checkOutput("rstmid_pend_1",   32'(bus.pending_1),  32'd0);
    checkOutput("rstmid_pend_2",   32'(bus.pending_2),  32'd0);
    checkOutput("rstmid_ready",    32'(bus.mc_ready),   32'd1);

    // Mixed traffic, checked by the model alone
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].pwe, vecs[i].preg, vecs[i].pdata,
                    vecs[i].mv, vecs[i].mreg, vecs[i].mdata, vecs[i].q1, vecs[i].q2);
    end
    drainFifo();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    peek();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
